frame_buffer_scheduler: RTL and testbench
=========================================

Name: frame_buffer_scheduler

Overview:
- Controller that sequences a multi-slot frame BRAM used as a row-in, column-out transpose buffer in the disparity filtering path.
- Generates write addresses for the incoming row-major pixel stream and column-major read addresses for the downstream filter.
- Tracks slot occupancy, backpressures the writer when all slots are full, and paces reads with a one-cycle-ahead downstream ready.

Parameters:
- width, 120, pixels per row.
- height, 240, rows per stored frame (read extent).
- wr_height, 240, rows actually written per frame; vertically centred, wr_height <= height.
- num_slots, 2, frame slots in the BRAM (>= 1).
- addr_w, $clog2(width*height*num_slots), BRAM address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- in_valid  in  1  upstream pixel present
- in_ready  out  1  scheduler can accept a pixel
- wr_en  out  1  BRAM write strobe
- wr_addr  out  addr_w  BRAM write address
- rd_en  out  1  BRAM read issue
- rd_addr  out  addr_w  BRAM read address
- out_ready  in  1  downstream permits a read issue this cycle
- out_valid  out  1  BRAM read data valid this cycle
- out_sof  out  1  first pixel of frame, qualified by out_valid
- out_eof  out  1  last pixel of frame, qualified by out_valid
- frames_held  out  $clog2(num_slots+1)  complete unread frames

Behaviour:
- Clock and reset: one clock `clk`; `reset_n` is asynchronous, active-low.
- Reset state:
  - All registers clear.
  - frames_held=0, wr_slot=0, rd_slot=0, row/col counters 0, state IDLE.
  - out_valid, out_sof, out_eof and rd_en are 0.
  - in_ready=1.
  - Reset asserted mid-frame abandons both the partial write and the partial read; no completion is counted.
- Derived constants:
  - FS = width*height.
  - WB = width*(height-wr_height)/2.
  - WE = WB + width*wr_height.
- Write side:
  - in_ready = (frames_held < num_slots), combinational from the registered count.
  - wr_en = in_valid & in_ready.
  - wr_addr = wr_slot*FS + wr_ptr, combinational; wr_ptr starts at WB.
  - Each wr_en increments wr_ptr.
  - On wr_en with wr_ptr==WE-1: wr_ptr<=WB, wr_slot<=(wr_slot+1) mod num_slots, write-complete event.
  - in_valid while in_ready=0 is ignored; upstream holds the pixel.
- Read side FSM:
  - IDLE: if frames_held>0, go READ next cycle with row=0, col=0.
  - READ:
    - rd_en = out_ready.
    - rd_addr = rd_slot*FS + row*width + col, combinational.
    - On each rd_en: row increments; at row==height-1, row<=0 and col increments.
    - On rd_en with row==height-1 and col==width-1: read-complete event, rd_slot advances mod num_slots, go IDLE.
  - There is always exactly one IDLE cycle between frames.
- Output timing:
  - out_valid is rd_en delayed 1 cycle, aligned with BRAM read latency 1.
  - out_sof and out_eof are likewise registered copies of the first and last issue.
  - out_ready is an advance permit. Data with out_valid=1 must be consumed regardless of out_ready in that cycle.
- frames_held:
  - +1 on write-complete, -1 on read-complete.
  - Both events in the same cycle leave it unchanged.
  - Never exceeds num_slots and never underflows, guaranteed by in_ready and IDLE gating.
- Slot contents: rows outside the WB..WE band are read as whatever the BRAM holds; the scheduler does not clear them.
- Collisions: the read slot is never the slot being written, because the writer is blocked when frames_held==num_slots.
- Arithmetic: all address terms are computed at addr_w bits; slot base multiplies are constant-foldable, with no runtime multiplier required.

Test Plan:
1. Reset check (width=4, height=3, wr_height=3, num_slots=2): assert reset_n=0 mid-run -> outputs clear immediately; in_ready=1, frames_held=0, out_valid=0.
2. Single frame, same params:
   - Stimulus: 12 pixels with in_valid=1, out_ready=1.
   - Writes: wr_addr 0..11, frames_held=1 one cycle after the last write.
   - Reads: after one IDLE cycle, rd_addr 0,4,8,1,5,9,2,6,10,3,7,11.
   - Outputs: out_valid one cycle after each rd_en, out_sof with addr 0, out_eof with addr 11, frames_held back to 0.
3. Full stall (out_ready=0): stream 30 pixels -> wr_addr 0..23, then in_ready=0 with frames_held=2 and wr_en=0 for the remaining 6. Raise out_ready -> reads start at slot 0; in_ready returns to 1 the cycle after read-complete.
4. Toggling out_ready (1,0,0,1,...): rd_en only in cycles with out_ready=1; the address sequence matches scenario 2 with no gaps or repeats; out_valid count = 12.
5. Simultaneous events: time the last write of frame 2 to the same cycle as read-complete of frame 1 -> frames_held stays 1, and the next read slot is 1.
6. Centred band (height=3, wr_height=1, width=4): WB=4 -> frame 0 writes addr 4..7; frame 1 writes addr 16..19; wr_slot wraps to 0 after frame 2.

Source files
------------

// File: rtl/frame_buffer_scheduler.sv
// Address sequencer for a multi-slot transpose frame buffer.
// Pixels are written row-major into the current write slot. Completed
// frames are read back column-major, and each read is issued one cycle
// before the data is due because the BRAM has one cycle of read latency.
module frame_buffer_scheduler #(
  parameter int width     = 120,
  parameter int height    = 240,
  parameter int wr_height = 240,
  parameter int num_slots = 2,
  parameter int addr_w    = $clog2(width*height*num_slots)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           wr_en,
  output logic [addr_w-1:0]              wr_addr,
  output logic                           rd_en,
  output logic [addr_w-1:0]              rd_addr,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic                           out_sof,
  output logic                           out_eof,
  output logic [$clog2(num_slots+1)-1:0] frames_held
);

  localparam int FS     = width * height;
  localparam int WB     = width * (height - wr_height) / 2;
  localparam int WE     = WB + width * wr_height;
  localparam int slot_w = (num_slots > 1) ? $clog2(num_slots) : 1;
  localparam int row_w  = (height > 1) ? $clog2(height) : 1;
  localparam int col_w  = (width > 1) ? $clog2(width) : 1;
  localparam int held_w = $clog2(num_slots + 1);

  localparam logic [addr_w-1:0] WB_A      = addr_w'(WB);
  localparam logic [addr_w-1:0] WE_LAST_A = addr_w'(WE - 1);
  localparam logic [addr_w-1:0] WIDTH_A   = addr_w'(width);
  localparam logic [slot_w-1:0] SLOT_LAST = slot_w'(num_slots - 1);
  localparam logic [row_w-1:0]  ROW_LAST  = row_w'(height - 1);
  localparam logic [col_w-1:0]  COL_LAST  = col_w'(width - 1);
  localparam logic [held_w-1:0] HELD_MAX  = held_w'(num_slots);

  typedef enum logic {IDLE, READ} state_t;

  state_t              state;
  logic [slot_w-1:0]   wr_slot;
  logic [slot_w-1:0]   rd_slot;
  logic [addr_w-1:0]   wr_ptr;
  logic [row_w-1:0]    row;
  logic [col_w-1:0]    col;
  logic                wr_done;
  logic                rd_done;
  logic                rd_first;

  // Slot base addresses are elaboration-time constants, so no multiplier
  // is needed to locate a slot.
  logic [addr_w-1:0] slot_base [num_slots];
  for (genvar gi = 0; gi < num_slots; gi++) begin : g_slot_base
    assign slot_base[gi] = addr_w'(gi * FS);
  end

  // Write side: accept whenever a free slot exists.
  assign in_ready = (frames_held < HELD_MAX);
  assign wr_en    = in_valid & in_ready;
  assign wr_addr  = slot_base[wr_slot] + wr_ptr;
  assign wr_done  = wr_en & (wr_ptr == WE_LAST_A);

  // Read side: issue only while reading and permitted downstream.
  assign rd_en    = (state == READ) & out_ready;
  assign rd_addr  = slot_base[rd_slot] + addr_w'(row) * WIDTH_A + addr_w'(col);
  assign rd_first = rd_en & (row == '0) & (col == '0);
  assign rd_done  = rd_en & (row == ROW_LAST) & (col == COL_LAST);

  // Write pointer walks the centred band, then moves to the next slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= WB_A;
      wr_slot <= '0;
    end else if (wr_en) begin
      if (wr_done) begin
        wr_ptr  <= WB_A;
        wr_slot <= (wr_slot == SLOT_LAST) ? '0 : wr_slot + 1'b1;
      end else begin
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

  // Read FSM: column-major walk of one slot, one IDLE cycle between frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      rd_slot <= '0;
    end else begin
      case (state)
        IDLE: begin
          row <= '0;
          col <= '0;
          if (frames_held != '0) state <= READ;
        end
        READ: begin
          if (rd_en) begin
            if (row == ROW_LAST) begin
              row <= '0;
              col <= col + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
            if (rd_done) begin
              rd_slot <= (rd_slot == SLOT_LAST) ? '0 : rd_slot + 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output flags follow the read issue by the BRAM's one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_sof   <= rd_first;
      out_eof   <= rd_done;
    end
  end

  // Occupancy count: a write and a read completing together cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_held <= '0;
    end else begin
      case ({wr_done, rd_done})
        2'b10:   frames_held <= frames_held + 1'b1;
        2'b01:   frames_held <= frames_held - 1'b1;
        default: frames_held <= frames_held;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler: a 4x3 two-slot instance for
// full-height frames and a second instance with a one-row centred band.
module tb_frame_buffer_scheduler;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NS = 2;
  localparam int AW = $clog2(W*H*NS);
  localparam int HW = $clog2(NS+1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, wr_en, rd_en, out_valid, out_sof, out_eof;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [HW-1:0] frames_held;

  logic in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic in_ready_b, wr_en_b, rd_en_b, out_valid_b, out_sof_b, out_eof_b;
  logic [AW-1:0] wr_addr_b, rd_addr_b;
  logic [HW-1:0] frames_held_b;

  frame_buffer_scheduler #(.width(W), .height(H), .wr_height(3), .num_slots(NS)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .out_ready(out_ready), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .frames_held(frames_held));

  frame_buffer_scheduler #(.width(W), .height(H), .wr_height(1), .num_slots(NS)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .out_ready(out_ready_b), .out_valid(out_valid_b), .out_sof(out_sof_b),
    .out_eof(out_eof_b), .frames_held(frames_held_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int exp_wr_a[$], exp_rd_a[$], exp_out_a[$];
  int exp_wr_b[$], exp_rd_b[$];
  int valid_cnt_a = 0, eof_cnt_a = 0, wr_cnt_b = 0, eof_cnt_b = 0;
  logic prev_rd_a = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_writes_a(input int base, input int n);
    for (int i = 0; i < n; i++) exp_wr_a.push_back(base + i);
  endtask

  // Column-major read order of one slot plus the sof/eof code per beat.
  task automatic push_frame_a(input int slot);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++) begin
        exp_rd_a.push_back(slot*W*H + r*W + c);
        exp_out_a.push_back(((c == 0 && r == 0) ? 2 : 0) | ((c == W-1 && r == H-1) ? 1 : 0));
      end
  endtask

  task automatic push_frame_b(input int slot);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++) exp_rd_b.push_back(slot*W*H + r*W + c);
  endtask

  task automatic wait_eof_a(input int target);
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (eof_cnt_a >= target) break;
    end
    check("eof_count_a", eof_cnt_a, target);
  endtask

  // Scoreboard for instance A, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rd_a = 1'b0;
    end else begin
      check("out_valid_lag_a", out_valid, prev_rd_a);
      prev_rd_a = rd_en;
      if (wr_en) begin
        $display("A write addr=%0d", wr_addr);
        if (exp_wr_a.size() == 0) check("wr_extra_a", exp_wr_a.size(), 1);
        else check("wr_addr_a", wr_addr, exp_wr_a.pop_front());
      end
      if (rd_en) begin
        $display("A read  addr=%0d", rd_addr);
        check("rd_permit_a", out_ready, 1);
        if (exp_rd_a.size() == 0) check("rd_extra_a", exp_rd_a.size(), 1);
        else check("rd_addr_a", rd_addr, exp_rd_a.pop_front());
      end
      if (out_valid) begin
        valid_cnt_a++;
        if (out_eof) eof_cnt_a++;
        if (exp_out_a.size() == 0) check("out_extra_a", exp_out_a.size(), 1);
        else check("sof_eof_a", {out_sof, out_eof}, exp_out_a.pop_front());
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en_b) begin
        $display("B write addr=%0d", wr_addr_b);
        wr_cnt_b++;
        if (exp_wr_b.size() == 0) check("wr_extra_b", exp_wr_b.size(), 1);
        else check("wr_addr_b", wr_addr_b, exp_wr_b.pop_front());
      end
      if (rd_en_b) begin
        $display("B read  addr=%0d", rd_addr_b);
        if (exp_rd_b.size() == 0) check("rd_extra_b", exp_rd_b.size(), 1);
        else check("rd_addr_b", rd_addr_b, exp_rd_b.pop_front());
      end
      if (out_valid_b && out_eof_b) eof_cnt_b++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, v0;
    logic found;

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_frames_held", frames_held, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", rd_en, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single frame with reads permitted.
    push_writes_a(0, 12);
    push_frame_a(0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (12) cycle();
    in_valid = 1'b0;
    check("s2_held_after_write", frames_held, 1);
    wait_eof_a(1);
    check("s2_held_after_read", frames_held, 0);
    check("s2_valid_count", valid_cnt_a, 12);

    // Asynchronous reset in the middle of a read.
    out_ready = 1'b0;
    push_writes_a(12, 12);
    in_valid = 1'b1;
    repeat (12) cycle();
    in_valid = 1'b0;
    check("mid_held_one", frames_held, 1);
    cycle();
    for (int r = 0; r < 3; r++) begin
      exp_rd_a.push_back(12 + r*W);
      exp_out_a.push_back(r == 0 ? 2 : 0);
    end
    out_ready = 1'b1;
    repeat (3) cycle();
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_frames_held", frames_held, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_reads_issued", exp_rd_a.size(), 0);
    exp_out_a.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full stall: 30 offered pixels, only 24 accepted.
    push_writes_a(0, 24);
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (k >= 23) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_held", frames_held, 2);
        check("stall_wr_en", wr_en, 0);
      end
    end
    in_valid = 1'b0;
    push_frame_a(0);
    push_frame_a(1);
    e0 = eof_cnt_a;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (rd_en && rd_addr == 5'd11) begin found = 1'b1; break; end
    end
    check("stall_last_issue_seen", found, 1);
    check("stall_ready_before_done", in_ready, 0);
    cycle();
    check("stall_ready_after_done", in_ready, 1);
    check("stall_held_after_done", frames_held, 1);

    // Toggled permit while slot 1 is read.
    wait_eof_a(e0 + 1);
    v0 = valid_cnt_a;
    for (int k = 0; k < 300; k++) begin
      out_ready = (k % 3 == 0);
      cycle();
      if (eof_cnt_a >= e0 + 2) break;
    end
    out_ready = 1'b0;
    check("toggle_eof", eof_cnt_a, e0 + 2);
    check("toggle_valid_count", valid_cnt_a - v0, 12);
    check("toggle_held", frames_held, 0);

    // Write-complete and read-complete on the same edge.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    push_writes_a(0, 24);
    push_frame_a(0);
    push_frame_a(1);
    e0 = eof_cnt_a;
    in_valid = 1'b1;
    repeat (23) cycle();
    in_valid = 1'b0;
    check("sim_held_pre", frames_held, 1);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd_en && rd_addr == 5'd11) begin found = 1'b1; break; end
      cycle();
    end
    check("sim_last_issue_seen", found, 1);
    in_valid = 1'b1;
    check("sim_in_ready", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    check("sim_held_same", frames_held, 1);
    wait_eof_a(e0 + 2);
    check("sim_held_end", frames_held, 0);
    out_ready = 1'b0;

    // Centred one-row band on instance B, three frames so the slot wraps.
    for (int i = 0; i < 4; i++) exp_wr_b.push_back(4 + i);
    for (int i = 0; i < 4; i++) exp_wr_b.push_back(16 + i);
    for (int i = 0; i < 4; i++) exp_wr_b.push_back(4 + i);
    push_frame_b(0);
    push_frame_b(1);
    push_frame_b(0);
    in_valid_b  = 1'b1;
    out_ready_b = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (wr_cnt_b >= 12) in_valid_b = 1'b0;
      if (wr_cnt_b >= 12 && eof_cnt_b >= 3) break;
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    check("band_writes", wr_cnt_b, 12);
    check("band_frames_read", eof_cnt_b, 3);
    check("band_held_end", frames_held_b, 0);

    // Every expectation consumed.
    check("left_wr_a", exp_wr_a.size(), 0);
    check("left_rd_a", exp_rd_a.size(), 0);
    check("left_out_a", exp_out_a.size(), 0);
    check("left_wr_b", exp_wr_b.size(), 0);
    check("left_rd_b", exp_rd_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
